config_loader: RTL and testbench

//   Writer side of the fabric configuration bus. Accepts a word-serial bitstream over a

---
 rtl/config_loader.sv | 145 ++++++++++++++
 tb/tb_config_loader.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/config_loader.sv
// Fabric configuration writer: assembles a word-serial bitstream in a shadow register and
// commits it atomically to config_out. Optional trailer checksum: CONFIG_LOADER_CHECKSUM_EN.
module config_loader #(
    parameter int CONFIG_WIDTH = 1746,
    parameter int WORD_WIDTH   = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic [WORD_WIDTH-1:0]   data_in,
    input  logic                    data_valid,
    output logic                    data_ready,
    output logic                    busy,
    output logic                    config_done,
    output logic                    config_error,
    output logic [CONFIG_WIDTH-1:0] config_out
);
    localparam int NUM_WORDS = (CONFIG_WIDTH + WORD_WIDTH - 1) / WORD_WIDTH;
    localparam int CNT_W     = $clog2(NUM_WORDS);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
`ifdef CONFIG_LOADER_CHECKSUM_EN
        CHECK,
`endif
        COMMIT
    } state_t;

    state_t                  state, state_nxt;
    logic [CNT_W-1:0]        cnt;
    logic [CONFIG_WIDTH-1:0] shadow;
    logic                    take, restart, commit, reject;
`ifdef CONFIG_LOADER_CHECKSUM_EN
    logic [WORD_WIDTH-1:0]   csum;
    logic                    err_q;
`endif

    always_comb begin
        state_nxt  = state;
        data_ready = 1'b0;
        busy       = 1'b0;
        take       = 1'b0;
        restart    = 1'b0;
        commit     = 1'b0;
        reject     = 1'b0;
        case (state)
            IDLE: ;
            LOAD: begin
                data_ready = 1'b1;
                busy       = 1'b1;
                if (data_valid) begin
                    take = 1'b1;
`ifdef CONFIG_LOADER_CHECKSUM_EN
                    if (cnt == LAST) state_nxt = CHECK;
`else
                    if (cnt == LAST) state_nxt = COMMIT;
`endif
                end
            end
`ifdef CONFIG_LOADER_CHECKSUM_EN
            CHECK: begin
                data_ready = 1'b1;
                busy       = 1'b1;
                if (data_valid) begin
                    if (data_in == csum) begin
                        state_nxt = COMMIT;
                    end else begin
                        reject    = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
`endif
            COMMIT: begin
                busy      = 1'b1;
                commit    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // start wins over everything: the word on this edge is dropped, nothing commits
        if (start) begin
            restart   = 1'b1;
            take      = 1'b0;
            commit    = 1'b0;
            reject    = 1'b0;
            state_nxt = LOAD;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            config_out  <= '0;
            config_done <= 1'b0;
`ifdef CONFIG_LOADER_CHECKSUM_EN
            csum        <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            if (restart) begin
                cnt         <= '0;
                config_done <= 1'b0;
`ifdef CONFIG_LOADER_CHECKSUM_EN
                csum        <= '0;
                err_q       <= 1'b0;
`endif
            end else if (take) begin
                if (cnt != LAST) cnt <= cnt + 1'b1;
`ifdef CONFIG_LOADER_CHECKSUM_EN
                csum <= csum ^ data_in;
`endif
            end
            if (commit) begin
                config_out  <= shadow;
                config_done <= 1'b1;
            end
`ifdef CONFIG_LOADER_CHECKSUM_EN
            if (reject) err_q <= 1'b1;
`endif
        end
    end

    // Per-bit word select; bits of the last word past CONFIG_WIDTH simply have no target
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shadow <= '0;
        end else if (take) begin
            for (int b = 0; b < CONFIG_WIDTH; b++) begin
                if (CNT_W'(b / WORD_WIDTH) == cnt) shadow[b] <= data_in[b % WORD_WIDTH];
            end
        end
    end

`ifdef CONFIG_LOADER_CHECKSUM_EN
    assign config_error = err_q;
`else
    assign config_error = 1'b0;
`endif

endmodule

// File: tb/tb_config_loader.sv
// Directed bench for config_loader: frame commit timing, stalls, async reset, restart,
// and the trailer checksum when CONFIG_LOADER_CHECKSUM_EN is defined.
module tb_config_loader;
    localparam int CW = 1746;
    localparam int WW = 8;
    localparam int NW = 219;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [WW-1:0] data_in = '0;
    logic          data_valid = 1'b0;
    logic          data_ready, busy, config_done, config_error;
    logic [CW-1:0] config_out;

    int n_chk = 0;
    int n_err = 0;

    config_loader #(.CONFIG_WIDTH(CW), .WORD_WIDTH(WW)) dut (
        .clock(clock), .reset(reset), .start(start), .data_in(data_in),
        .data_valid(data_valid), .data_ready(data_ready), .busy(busy),
        .config_done(config_done), .config_error(config_error), .config_out(config_out)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [CW-1:0] pat(input logic [7:0] b);
        logic [NW*WW-1:0] full;
        full = {NW{b}};
        return full[CW-1:0];
    endfunction

    // number of config_out bits that differ from the expected frame
    function automatic logic [63:0] diff(input logic [CW-1:0] exp);
        return 64'($countones(config_out ^ exp));
    endfunction

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    // Presents n words; returns at #1 after the edge that accepted the last one
    task automatic send(input string tag, input int n, input logic [7:0] b, input bit toggle);
        int acc = 0;
        int cyc = 0;
        bit v = 1'b1;
        while (acc < n && cyc < 4 * n + 10) begin
            data_in    = b;
            data_valid = v;
            @(negedge clock);
            if (data_ready && v) acc++;
            @(posedge clock); #1;
            cyc++;
            if (toggle) v = !v;
        end
        data_valid = 1'b0;
        chk(tag, 64'(acc), 64'(n));
    endtask

    task automatic send_trailer(input logic [7:0] b);
`ifdef CONFIG_LOADER_CHECKSUM_EN
        send("trailer_accept", 1, b, 1'b0);
`else
        if (b == 8'hxx) $display("unused");
`endif
    endtask

    task automatic check_commit(input string tag, input logic [CW-1:0] old_cfg,
                                input logic [CW-1:0] new_cfg);
        chk({tag, "_ready_low"}, 64'(data_ready), 64'd0);
        chk({tag, "_busy_commit"}, 64'(busy), 64'd1);
        chk({tag, "_done_pre"}, 64'(config_done), 64'd0);
        chk({tag, "_cfg_pre"}, diff(old_cfg), 64'd0);
        @(posedge clock); #1;
        chk({tag, "_cfg"}, diff(new_cfg), 64'd0);
        chk({tag, "_done"}, 64'(config_done), 64'd1);
        chk({tag, "_busy_idle"}, 64'(busy), 64'd0);
        chk({tag, "_error"}, 64'(config_error), 64'd0);
    endtask

    initial begin
        logic [CW-1:0] ones;
        logic [CW-1:0] zero;
        ones = '1;
        zero = '0;

        #1;
        chk("rst_ready", 64'(data_ready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(config_done), 64'd0);
        chk("rst_error", 64'(config_error), 64'd0);
        chk("rst_cfg", diff(zero), 64'd0);
        @(posedge clock); #1;
        reset = 1'b0;

        // data_valid is ignored while idle
        data_valid = 1'b1;
        data_in    = 8'h11;
        @(posedge clock); #1;
        chk("idle_ready", 64'(data_ready), 64'd0);
        data_valid = 1'b0;

        // back-to-back 0xA5 frame
        pulse_start();
        chk("load_busy", 64'(busy), 64'd1);
        chk("load_ready", 64'(data_ready), 64'd1);
        send("t1_words", NW, 8'hA5, 1'b0);
        send_trailer(8'hA5);
        check_commit("t1", zero, pat(8'hA5));
        chk("t1_top2", 64'(config_out[CW-1:CW-2]), 64'd1);
        chk("t1_low", 64'(config_out[63:0]), 64'hA5A5A5A5A5A5A5A5);

        // all-ones frame, partial load, async reset mid-cycle
        pulse_start();
        send("t3_ff", NW, 8'hFF, 1'b0);
        send_trailer(8'hFF);
        check_commit("t3c", pat(8'hA5), ones);
        pulse_start();
        send("t3_part", 100, 8'h00, 1'b0);
        chk("t3_hold", diff(ones), 64'd0);
        #2 reset = 1'b1;
        #1;
        chk("t3_cfg_zero", diff(zero), 64'd0);
        chk("t3_ready", 64'(data_ready), 64'd0);
        chk("t3_busy", 64'(busy), 64'd0);
        chk("t3_done", 64'(config_done), 64'd0);
        @(posedge clock); #1;
        reset = 1'b0;

        // 0xA5 frame with data_valid toggling every cycle
        pulse_start();
        send("t2_words", NW, 8'hA5, 1'b1);
        send_trailer(8'hA5);
        check_commit("t2", zero, pat(8'hA5));

        // restart mid-load; word presented with start must be dropped
        pulse_start();
        send("t4_ff", NW, 8'hFF, 1'b0);
        send_trailer(8'hFF);
        check_commit("t4c", pat(8'hA5), ones);
        pulse_start();
        send("t4_part", 50, 8'h00, 1'b0);
        start      = 1'b1;
        data_valid = 1'b1;
        data_in    = 8'h99;
        @(posedge clock); #1;
        start      = 1'b0;
        data_valid = 1'b0;
        chk("t4_done_clr", 64'(config_done), 64'd0);
        chk("t4_cfg_kept", diff(ones), 64'd0);
        send("t4_a", 100, 8'h3C, 1'b0);
        chk("t4_done_mid", 64'(config_done), 64'd0);
        chk("t4_cfg_mid", diff(ones), 64'd0);
        send("t4_b", NW - 100, 8'h3C, 1'b0);
        send_trailer(8'h3C);
        check_commit("t4", ones, pat(8'h3C));

`ifdef CONFIG_LOADER_CHECKSUM_EN
        // odd count of 0xA5 words XORs to 0xA5
        pulse_start();
        send("t5_words", NW, 8'hA5, 1'b0);
        chk("t5_check_ready", 64'(data_ready), 64'd1);
        send_trailer(8'hA5);
        check_commit("t5", pat(8'h3C), pat(8'hA5));

        // bad trailer rejects the frame
        pulse_start();
        send("t6_words", NW, 8'hA5, 1'b0);
        send_trailer(8'h00);
        chk("t6_error", 64'(config_error), 64'd1);
        chk("t6_done", 64'(config_done), 64'd0);
        chk("t6_busy", 64'(busy), 64'd0);
        chk("t6_cfg", diff(pat(8'hA5)), 64'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
